// File: rtl/ping_pong_checker.sv
// ping_pong_checker: receive-side monitor for a ping-pong counter stream.
//
// Samples (cnt_in, dir_in) whenever valid is high and checks every
// transition against the legal ping-pong step (reflecting at 0 and MAX)
// or an exact hold. It counts accepted direction reversals and flags
// illegal transitions. All outputs are registered, so a sample taken at
// edge N is reflected after edge N.
//
// Optional build macro: PPC_STALL_DETECT_EN
//   When defined, a hold counter raises stall after STALL_LIMIT
//   consecutive accepted holds. When undefined, stall is a constant 0.
//
// Parameters:
//   WIDTH       - width of the observed counter value (MAX = 2**WIDTH-1)
//   BOUNCE_W    - width of the saturating bounce counter
//   STALL_LIMIT - hold count that raises stall (optional feature only)
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   valid      - cnt_in/dir_in carry a sample this cycle
//   cnt_in     - observed counter value
//   dir_in     - observed direction (1 = up)
//   resync     - drop lock, clear sticky error, re-acquire on next sample
//   locked     - high while tracking
//   err_pulse  - one-cycle pulse on an illegal transition
//   err_sticky - set by any error, cleared by rst or resync
//   bounce_cnt - accepted direction reversals, saturating
//   stall      - hold-limit indicator (0 when the feature is compiled out)

module ping_pong_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned BOUNCE_W    = 8,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [WIDTH-1:0]    cnt_in,
  input  logic                dir_in,
  input  logic                resync,
  output logic                locked,
  output logic                err_pulse,
  output logic                err_sticky,
  output logic [BOUNCE_W-1:0] bounce_cnt,
  output logic                stall
);

  localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pv;
  logic             pd;

  logic [WIDTH-1:0] step_v;
  logic             step_d;
  logic             is_hold;
  logic             is_step;
  logic             is_bounce;

  // Expected next value from the stored sample; both ends reflect.
  always_comb begin
    step_v = pv;
    step_d = pd;
    if (pv == MAX_V) begin
      step_v = MAX_V - WIDTH'(1);
      step_d = 1'b0;
    end else if (pv == '0) begin
      step_v = WIDTH'(1);
      step_d = 1'b1;
    end else if (pd) begin
      step_v = pv + WIDTH'(1);
      step_d = 1'b1;
    end else begin
      step_v = pv - WIDTH'(1);
      step_d = 1'b0;
    end
  end

  // Classify the incoming sample against the stored one.
  always_comb begin
    is_hold   = (cnt_in == pv) && (dir_in == pd);
    is_step   = (cnt_in == step_v) && (dir_in == step_d);
    is_bounce = is_step && (dir_in != pd);
  end

  // Checker FSM with registered outputs; resync outranks valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pv         <= '0;
      pd         <= 1'b1;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (resync) begin
        state      <= IDLE;
        locked     <= 1'b0;
        err_sticky <= 1'b0;
      end else if (valid) begin
        case (state)
          IDLE: begin
            // First sample after acquisition is taken on trust.
            pv     <= cnt_in;
            pd     <= dir_in;
            state  <= TRACK;
            locked <= 1'b1;
          end
          TRACK: begin
            if (is_hold) begin
              locked <= 1'b1;
            end else if (is_step) begin
              pv     <= cnt_in;
              pd     <= dir_in;
              locked <= 1'b1;
              if (is_bounce && (bounce_cnt != {BOUNCE_W{1'b1}})) begin
                bounce_cnt <= bounce_cnt + BOUNCE_W'(1);
              end
            end else begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              state      <= FAULT;
              locked     <= 1'b0;
            end
          end
          FAULT: begin
            locked <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PPC_STALL_DETECT_EN
  localparam int unsigned HC_W = $clog2(STALL_LIMIT + 1);

  logic [HC_W-1:0] hold_cnt;
  logic            tracking;
  logic            acc_hold;
  logic            acc_step;
  logic            trk_err;

  always_comb begin
    tracking = (state == TRACK) && valid && !resync;
    acc_hold = tracking && is_hold;
    acc_step = tracking && !is_hold && is_step;
    trk_err  = tracking && !is_hold && !is_step;
  end

  // Consecutive-hold counter; stall latches until a step, resync or rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      stall    <= 1'b0;
    end else if (resync || acc_step) begin
      hold_cnt <= '0;
      stall    <= 1'b0;
    end else if (trk_err) begin
      hold_cnt <= '0;
    end else if (acc_hold && (hold_cnt != HC_W'(STALL_LIMIT))) begin
      hold_cnt <= hold_cnt + HC_W'(1);
      if (hold_cnt == HC_W'(STALL_LIMIT - 1)) begin
        stall <= 1'b1;
      end
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_ping_pong_checker.sv
// Directed self-checking bench for ping_pong_checker (default parameters).
module tb_ping_pong_checker;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [3:0] cnt_in;
  logic       dir_in;
  logic       resync;
  logic       locked;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] bounce_cnt;
  logic       stall;

  int checks = 0;
  int errors = 0;

`ifdef PPC_STALL_DETECT_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif

  ping_pong_checker #(
    .WIDTH      (4),
    .BOUNCE_W   (8),
    .STALL_LIMIT(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .cnt_in    (cnt_in),
    .dir_in    (dir_in),
    .resync    (resync),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .bounce_cnt(bounce_cnt),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [3:0] c, input logic d, input logic rs);
    valid  = v;
    cnt_in = c;
    dir_in = d;
    resync = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; cnt_in = '0; dir_in = 1'b0; resync = 1'b0;
    #2;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_errp", 32'(err_pulse), 32'd0);
    check("rst_errs", 32'(err_sticky), 32'd0);
    check("rst_bounce", 32'(bounce_cnt), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    #10 rst = 1'b0;

    // Legal sweep 0..15 up, 14..0 down, then 1 up.
    cyc(1, 4'd0, 1, 0);
    check("acq_locked", 32'(locked), 32'd1);
    for (int x = 1; x <= 15; x++) cyc(1, 4'(x), 1, 0);
    check("top_bounce", 32'(bounce_cnt), 32'd0);
    cyc(1, 4'd14, 0, 0);
    check("refl_top_bounce", 32'(bounce_cnt), 32'd1);
    for (int x = 13; x >= 0; x--) cyc(1, 4'(x), 0, 0);
    cyc(1, 4'd1, 1, 0);
    check("sweep_locked", 32'(locked), 32'd1);
    check("sweep_errs", 32'(err_sticky), 32'd0);
    check("sweep_bounce", 32'(bounce_cnt), 32'd2);

    // Skip from (5,1) to (7,1) is illegal.
    for (int x = 2; x <= 5; x++) cyc(1, 4'(x), 1, 0);
    cyc(1, 4'd7, 1, 0);
    check("skip_errp", 32'(err_pulse), 32'd1);
    check("skip_errs", 32'(err_sticky), 32'd1);
    check("skip_locked", 32'(locked), 32'd0);
    cyc(1, 4'd6, 1, 0);
    check("fault_errp", 32'(err_pulse), 32'd0);
    check("fault_errs", 32'(err_sticky), 32'd1);
    check("fault_locked", 32'(locked), 32'd0);
    check("fault_bounce", 32'(bounce_cnt), 32'd2);

    // resync beats a simultaneous valid.
    cyc(1, 4'd3, 0, 1);
    check("resync_locked", 32'(locked), 32'd0);
    check("resync_errs", 32'(err_sticky), 32'd0);
    cyc(1, 4'd3, 0, 0);
    check("reacq_locked", 32'(locked), 32'd1);
    check("reacq_errp", 32'(err_pulse), 32'd0);

    // Hold (9,0) ten times with gaps, then step down.
    cyc(0, 4'd0, 0, 1);
    cyc(1, 4'd9, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 4'd9, 0, 0);
      cyc(0, 4'd2, 1, 0);
    end
    check("hold_locked", 32'(locked), 32'd1);
    check("hold_errs", 32'(err_sticky), 32'd0);
    cyc(1, 4'd8, 0, 0);
    check("hold_step_errs", 32'(err_sticky), 32'd0);
    check("hold_step_bounce", 32'(bounce_cnt), 32'd2);

    // Direction mismatch after (9,0).
    cyc(0, 4'd0, 0, 1);
    cyc(1, 4'd9, 0, 0);
    cyc(1, 4'd8, 1, 0);
    check("dir_errp", 32'(err_pulse), 32'd1);
    check("dir_errs", 32'(err_sticky), 32'd1);

    // 299 further reversals drive the counter into saturation.
    cyc(0, 4'd0, 0, 1);
    cyc(1, 4'd0, 1, 0);
    for (int k = 0; k < 150; k++) begin
      for (int x = 1; x <= 15; x++) cyc(1, 4'(x), 1, 0);
      for (int x = 14; x >= 0; x--) cyc(1, 4'(x), 0, 0);
      if (k == 0) check("sat_early", 32'(bounce_cnt), 32'd3);
    end
    check("sat_bounce", 32'(bounce_cnt), 32'd255);
    check("sat_errs", 32'(err_sticky), 32'd0);

    // Error, then asynchronous reset while err_pulse is high.
    cyc(1, 4'd5, 1, 0);
    check("pre_rst_errp", 32'(err_pulse), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_errp", 32'(err_pulse), 32'd0);
    check("arst_errs", 32'(err_sticky), 32'd0);
    check("arst_bounce", 32'(bounce_cnt), 32'd0);
    #3 rst = 1'b0;

    // Hold (4,1) sixteen times, then step to (5,1).
    cyc(1, 4'd4, 1, 0);
    for (int i = 0; i < 15; i++) cyc(1, 4'd4, 1, 0);
    check("stall_15", 32'(stall), 32'd0);
    cyc(1, 4'd4, 1, 0);
    check("stall_16", 32'(stall), 32'(STALL_EN));
    check("stall_errs", 32'(err_sticky), 32'd0);
    cyc(1, 4'd5, 1, 0);
    check("stall_clr", 32'(stall), 32'd0);
    check("stall_bounce", 32'(bounce_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ping_pong_checker.md
Name: ping_pong_checker

Overview:
- Receive-side monitor for a ping-pong counter stream: samples the counter value and direction each cycle and checks that every transition is legal.
- Counts direction bounces and flags illegal transitions.
- Sits beside the counter on the lab board or bench; drives the LED/error indicators and self-check logic.

Parameters:
- WIDTH, 4, width of the observed counter value; MAX = 2**WIDTH-1.
- BOUNCE_W, 8, width of the bounce counter (saturating).
- STALL_LIMIT, 16, hold-cycle limit used only by the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid  input  1  cnt_in/dir_in carry a sample this cycle.
- cnt_in  input  WIDTH  observed counter value.
- dir_in  input  1  observed direction (1 = up).
- resync  input  1  drop lock and clear the sticky error; re-acquire on the next sample.
- locked  output  1  high in TRACK.
- err_pulse  output  1  one-cycle pulse on an illegal transition.
- err_sticky  output  1  set by any error; cleared only by rst or resync.
- bounce_cnt  output  BOUNCE_W  number of accepted direction reversals, saturating.
- stall  output  1  optional-feature output; tied to 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; locked=0; err_pulse=0; err_sticky=0; bounce_cnt=0; stall=0; stored sample (pv,pd)=(0,1).
- All outputs are registered. A sample presented at edge N is reflected at edge N+1 (1-cycle latency).
- Legal step function from stored (v,d):
  - v==MAX -> (MAX-1,0)
  - v==0 -> (1,1)
  - otherwise d=1 -> (v+1,1); d=0 -> (v-1,0)
- Legal hold: the sample equals (v,d) exactly (counter disabled).
- States:
  - IDLE: on valid, capture (cnt_in,dir_in) and go to TRACK. No check is performed on this first sample.
  - TRACK, on valid:
    - Sample equals hold or step: accept, update (pv,pd).
    - Accepted step with dir_in != pd: bounce_cnt+1, saturating at all-ones.
    - Anything else: err_pulse=1 for one cycle, err_sticky=1, go to FAULT. (pv,pd) is not updated.
  - FAULT: samples are ignored; locked=0. Remains in FAULT until resync.
  - valid=0 in any state: no state or counter change.
- resync (any state): go to IDLE, clear err_sticky, keep bounce_cnt. resync wins over a simultaneous valid; that sample is discarded.
- The hold check does not count toward bounces. Wrap-around never occurs: 0 and MAX both reflect.
- Reset mid-operation: immediate return to reset values regardless of state or pending pulse.

Optional Feature:
- Macro: PPC_STALL_DETECT_EN.
- Defined:
  - An internal hold counter increments on each accepted hold in TRACK and clears on any accepted step, resync, or leaving TRACK.
  - When it reaches STALL_LIMIT, stall=1 and stays 1 until the next accepted step, resync, or rst.
  - stall does not affect err_sticky.
- Undefined: no hold counter is built; stall is a constant 0.

Test Plan:
- Reset, then feed a legal stream from (0,1) up to (15,1), then (14,0) down to (0,0), then (1,1) -> locked=1 from the second cycle, err_sticky=0, bounce_cnt=2.
- While locked at (5,1), present (7,1) -> err_pulse high exactly one cycle, err_sticky=1, locked=0. A following legal (6,1) is ignored and bounce_cnt is unchanged.
- In FAULT, assert resync together with valid (3,0) -> state IDLE, err_sticky=0, sample discarded. Next valid (3,0) -> locked=1, no error.
- Hold (9,0) for 10 valid cycles with valid gaps interleaved, then step to (8,0) -> no error, bounce_cnt unchanged. Direction mismatch (8,1) after (9,0) -> error.
- Drive a reversing stream for 300 reversals with BOUNCE_W=8 -> bounce_cnt saturates at 255. Assert rst mid-stream -> all outputs 0 and locked=0 immediately, before the next clock edge.
- With PPC_STALL_DETECT_EN defined and STALL_LIMIT=16: hold (4,1) for 16 accepted holds -> stall=1; step to (5,1) -> stall=0 one cycle later. Without the macro, stall stays 0.
